// File: rtl/deltacache_ctrl.sv
// Single-port SRAM controller: read / write / optional accumulate (read-modify-write).
// Define DELTACACHE_ACC_EN to enable the accumulate op (op 10); otherwise op 10 is rejected like op 11.
module deltacache_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  req_err,
  output logic                  sram_cs_n,
  output logic                  sram_wr_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
`ifdef DELTACACHE_ACC_EN
  localparam logic [1:0] OP_ACC = 2'b10;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPT,
    RSP
`ifdef DELTACACHE_ACC_EN
    , ACC_WR
`endif
  } state_t;

  state_t                state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  req_err_q;
  logic                  sram_cs_n_q;
  logic                  sram_wr_n_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic [DATA_WIDTH-1:0] sram_wdata_q;
`ifdef DELTACACHE_ACC_EN
  logic                  acc_q;
`endif

  logic op_ok;
  logic accept;

`ifdef DELTACACHE_ACC_EN
  assign op_ok = (req_op == OP_RD) || (req_op == OP_WR) || (req_op == OP_ACC);
`else
  assign op_ok = (req_op == OP_RD) || (req_op == OP_WR);
`endif
  assign accept = req_valid && req_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      req_err_q    <= 1'b0;
      sram_cs_n_q  <= 1'b1;
      sram_wr_n_q  <= 1'b1;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
`ifdef DELTACACHE_ACC_EN
      acc_q        <= 1'b0;
`endif
    end else begin
      req_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            if (op_ok) begin
              // For accumulate the delta rides in sram_wdata_q while wr_n is high.
              state_q      <= ISSUE;
              req_ready_q  <= 1'b0;
              sram_cs_n_q  <= 1'b0;
              sram_wr_n_q  <= (req_op != OP_WR);
              sram_addr_q  <= req_addr;
              sram_wdata_q <= req_wdata;
`ifdef DELTACACHE_ACC_EN
              acc_q        <= (req_op == OP_ACC);
`endif
            end else begin
              req_err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          sram_cs_n_q <= 1'b1;
          sram_wr_n_q <= 1'b1;
          if (!sram_wr_n_q) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end else begin
            state_q <= CAPT;
          end
        end
        CAPT: begin
`ifdef DELTACACHE_ACC_EN
          if (acc_q) begin
            state_q      <= ACC_WR;
            sram_cs_n_q  <= 1'b0;
            sram_wr_n_q  <= 1'b0;
            sram_wdata_q <= sram_rdata + sram_wdata_q;
          end else begin
            state_q     <= RSP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= sram_rdata;
          end
`else
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= sram_rdata;
`endif
        end
        RSP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
`ifdef DELTACACHE_ACC_EN
        ACC_WR: begin
          state_q     <= IDLE;
          sram_cs_n_q <= 1'b1;
          sram_wr_n_q <= 1'b1;
          req_ready_q <= 1'b1;
        end
`endif
        default: begin
          state_q     <= IDLE;
          sram_cs_n_q <= 1'b1;
          sram_wr_n_q <= 1'b1;
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign req_err    = req_err_q;
  assign sram_cs_n  = sram_cs_n_q;
  assign sram_wr_n  = sram_wr_n_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

endmodule

// File: doc/deltacache_ctrl.md
DELTACACHE_CTRL -- requirements
Module: deltacache_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 6, SRAM word address width; DATA_WIDTH, 32, SRAM word width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_op  input  2  00 read, 01 write, 10 accumulate, 11 reserved.
REQ-007 req_addr  input  ADDR_WIDTH  target word.
REQ-008 req_wdata  input  DATA_WIDTH  write data or accumulate delta.
REQ-009 rsp_valid  output  1  read data available.
REQ-010 rsp_ready  input  1  response consumer ready.
REQ-011 rsp_data  output  DATA_WIDTH  read data.
REQ-012 req_err  output  1  one-cycle pulse when an unsupported op is dropped.
REQ-013 sram_cs_n, sram_wr_n  output  1 each  SRAM select and write strobe, active-low.
REQ-014 sram_addr  output  ADDR_WIDTH; sram_wdata  output  DATA_WIDTH; sram_rdata  input  DATA_WIDTH.

Function
REQ-015 The controller SHALL be the initiator for a single-port SRAM that registers its address on clk and returns sram_rdata for that address in the following cycle, and writes when cs_n=0 and wr_n=0 at the clock edge.
REQ-016 All sram_* outputs, req_ready, rsp_valid, rsp_data and req_err SHALL be driven from registers.
REQ-017 FSM states SHALL be IDLE, ISSUE, CAPT, RSP, ACC_WR; at most one request SHALL be outstanding.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted at the edge where req_valid and req_ready are both 1.
REQ-019 On acceptance, IDLE->ISSUE; in ISSUE the controller SHALL drive sram_cs_n=0, sram_addr=req_addr (captured), and for a write sram_wr_n=0 with sram_wdata=req_wdata (captured), else sram_wr_n=1.
REQ-020 Write: ISSUE->IDLE; no response SHALL be generated; req_ready SHALL be 1 again two cycles after the accept edge.
REQ-021 Read: ISSUE->CAPT (sram_cs_n=1), sram_rdata captured into rsp_data at end of CAPT, then RSP with rsp_valid=1 three cycles after the accept edge.
REQ-022 rsp_valid and rsp_data SHALL hold stable until rsp_ready=1; the cycle rsp_ready=1 is seen SHALL clear rsp_valid and return to IDLE.
REQ-023 Op 11 SHALL be accepted, SHALL cause no SRAM access, SHALL pulse req_err for one cycle, and SHALL leave the FSM in IDLE.
REQ-024 sram_cs_n and sram_wr_n SHALL be 1 in every state other than ISSUE and ACC_WR.
REQ-025 A write followed immediately by a read of the same address SHALL return the newly written data.

Reset
REQ-026 While rst_n=0: state=IDLE, sram_cs_n=1, sram_wr_n=1, sram_addr=0, sram_wdata=0, rsp_valid=0, rsp_data=0, req_err=0, req_ready=0.
REQ-027 req_ready SHALL become 1 at the first rising edge after rst_n deasserts.
REQ-028 Reset asserted mid-operation SHALL abort it: no subsequent SRAM write, any pending response discarded.

Configuration
REQ-029 Macro DELTACACHE_ACC_EN SHALL enable the accumulate op.
REQ-030 With DELTACACHE_ACC_EN: op 10 SHALL run ISSUE (read)->CAPT (sum = sram_rdata + delta, modulo 2^DATA_WIDTH, carry discarded)->ACC_WR (cs_n=0, wr_n=0, same address, sum)->IDLE; no response; req_ready 1 again four cycles after accept.
REQ-031 Without DELTACACHE_ACC_EN: op 10 SHALL behave exactly as op 11 and the ACC_WR state and adder SHALL not exist.

Verification
REQ-032 Reset, write 0xDEADBEEF to addr 5, read addr 5 -> rsp_valid 3 cycles after read accept, rsp_data=0xDEADBEEF.
REQ-033 Read with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout, one response delivered.
REQ-034 Back-to-back write addr 63 = 0x1 then read addr 63 -> rsp_data=0x1.
REQ-035 ACC_EN: addr 2 = 0xFFFFFFFF, accumulate delta 0x2 -> read returns 0x00000001; without ACC_EN -> req_err pulse, read returns 0xFFFFFFFF.
REQ-036 Op 11 -> req_err one cycle, sram_cs_n stays 1, next request accepted next cycle.
REQ-037 Assert rst_n=0 during ISSUE of a write -> sram_cs_n=1 immediately, all outputs at reset values, req_ready=1 one edge after release.
